// File: rtl/pip_pkg.sv
// Shared pipeline definitions for the memory stage: funct3 load/store codes,
// MEM FSM states and access-size decode.
package pip_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Unused funct3 codes fall back to a full-word access.
  function automatic access_size_e access_size(input logic [2:0] funct3, input logic is_store);
    access_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data lane selection and sign/zero extension for a 32-bit data word.
module load_align
  import pip_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_rdata,
  input  logic [1:0]   i_addr_lo,
  input  logic [2:0]   i_funct3,
  output logic [W-1:0] o_data_c
);

  logic [W-1:0] w_shift;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;

  always_comb begin
    w_shift  = i_rdata >> {i_addr_lo, 3'b000};
    w_byte   = w_shift[7:0];
    w_half   = w_shift[15:0];
    o_data_c = i_rdata;
    case (i_funct3)
      F3_LB:   o_data_c = {{(W-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data_c = {{(W-8){1'b0}}, w_byte};
      F3_LH:   o_data_c = {{(W-16){w_half[15]}}, w_half};
      F3_LHU:  o_data_c = {{(W-16){1'b0}}, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: zero-latency passthrough for non-memory instructions,
// stalling IDLE->REQ->RESP handshake for aligned loads/stores.
module mem_stage
  import pip_pkg::*;
#(
  parameter int unsigned IMMEDIATE_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [4:0]                 rd_in,
  input  logic [IMMEDIATE_WIDTH-1:0] pc_in,
  input  logic [IMMEDIATE_WIDTH-1:0] alu_res_in,
  input  logic [IMMEDIATE_WIDTH-1:0] sign_immediate_in,
  input  logic [IMMEDIATE_WIDTH-1:0] write_data_in,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [2:0]                 funct3_in,
  input  logic                       reg_write_en_in,
  input  logic [1:0]                 write_back_mux_in,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [IMMEDIATE_WIDTH-1:0] mem_addr,
  output logic [IMMEDIATE_WIDTH-1:0] mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  input  logic [IMMEDIATE_WIDTH-1:0] mem_rdata,
  output logic [4:0]                 rd_out,
  output logic [IMMEDIATE_WIDTH-1:0] pc_out,
  output logic [IMMEDIATE_WIDTH-1:0] alu_res_out,
  output logic [IMMEDIATE_WIDTH-1:0] sign_immediate_out,
  output logic [IMMEDIATE_WIDTH-1:0] data_mem_res_out,
  output logic                       reg_write_en_out,
  output logic [1:0]                 write_back_mux_out,
  output logic                       stall_out,
  output logic                       misalign_out
);

  localparam int unsigned W = IMMEDIATE_WIDTH;

  mem_state_e   r_state, w_next;
  logic [4:0]   r_rd;
  logic [W-1:0] r_pc, r_alu, r_imm, r_wdata, r_load;
  logic [3:0]   r_be;
  logic [2:0]   r_f3;
  logic         r_we, r_rwe;
  logic [1:0]   r_wbm;

  logic         w_is_mem, w_misalign, w_capture, w_take;
  access_size_e w_size;
  logic [3:0]   w_be;
  logic [W-1:0] w_wdata, w_load;

  // Decode of the incoming access: size, alignment, lane enables, replicated data.
  always_comb begin
    w_is_mem   = mem_read_in | mem_write_in;
    w_size     = access_size(funct3_in, mem_write_in);
    w_misalign = ((w_size == SZ_HALF) && alu_res_in[0]) ||
                 ((w_size == SZ_WORD) && (alu_res_in[1:0] != 2'b00));
    w_be       = 4'b1111;
    w_wdata    = write_data_in;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'(4'b0001 << alu_res_in[1:0]);
        w_wdata = {4{write_data_in[7:0]}};
      end
      SZ_HALF: begin
        w_be    = 4'(4'b0011 << alu_res_in[1:0]);
        w_wdata = {2{write_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = write_data_in;
      end
    endcase
  end

  load_align #(.W(W)) u_load_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_alu[1:0]),
    .i_funct3  (r_f3),
    .o_data_c  (w_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and MEM/WB-facing outputs; reset forces the bubble values.
  always_comb begin
    w_next             = r_state;
    w_capture          = 1'b0;
    w_take             = 1'b0;
    mem_req            = 1'b0;
    stall_out          = 1'b0;
    misalign_out       = 1'b0;
    reg_write_en_out   = 1'b0;
    data_mem_res_out   = '0;
    rd_out             = r_rd;
    pc_out             = r_pc;
    alu_res_out        = r_alu;
    sign_immediate_out = r_imm;
    write_back_mux_out = r_wbm;
    case (r_state)
      ST_IDLE: begin
        rd_out             = rd_in;
        pc_out             = pc_in;
        alu_res_out        = alu_res_in;
        sign_immediate_out = sign_immediate_in;
        write_back_mux_out = write_back_mux_in;
        if (valid_in) begin
          if (!w_is_mem) begin
            reg_write_en_out = reg_write_en_in;
          end else if (w_misalign) begin
            misalign_out = 1'b1;
          end else begin
            w_capture = 1'b1;
            stall_out = 1'b1;
            w_next    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        stall_out = 1'b1;
        if (mem_ack) begin
          w_take = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        reg_write_en_out = r_rwe;
        data_mem_res_out = r_load;
        w_next           = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (rst) begin
      mem_req          = 1'b0;
      stall_out        = 1'b0;
      misalign_out     = 1'b0;
      reg_write_en_out = 1'b0;
      data_mem_res_out = '0;
    end
  end

  // Payload capture and load-result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_pc    <= '0;
      r_alu   <= '0;
      r_imm   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_rwe   <= 1'b0;
      r_wbm   <= '0;
      r_load  <= '0;
    end else begin
      if (w_capture) begin
        r_rd    <= rd_in;
        r_pc    <= pc_in;
        r_alu   <= alu_res_in;
        r_imm   <= sign_immediate_in;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_f3    <= funct3_in;
        r_we    <= mem_write_in;
        r_rwe   <= reg_write_en_in;
        r_wbm   <= write_back_mux_in;
        r_load  <= '0;
      end
      if (w_take) r_load <= r_we ? '0 : w_load;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = {r_alu[W-1:2], 2'b00};
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, random ops against
// an arithmetic reference model, and reset corner sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [4:0]  rd_in;
  logic [31:0] pc_in, alu_res_in, sign_immediate_in, write_data_in;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic        reg_write_en_in;
  logic [1:0]  write_back_mux_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rd_out;
  logic [31:0] pc_out, alu_res_out, sign_immediate_out, data_mem_res_out;
  logic        reg_write_en_out;
  logic [1:0]  write_back_mux_out;
  logic        stall_out, misalign_out;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.IMMEDIATE_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .rd_in(rd_in), .pc_in(pc_in), .alu_res_in(alu_res_in),
    .sign_immediate_in(sign_immediate_in), .write_data_in(write_data_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .reg_write_en_in(reg_write_en_in), .write_back_mux_in(write_back_mux_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_out(rd_out), .pc_out(pc_out), .alu_res_out(alu_res_out),
    .sign_immediate_out(sign_immediate_out), .data_mem_res_out(data_mem_res_out),
    .reg_write_en_out(reg_write_en_out), .write_back_mux_out(write_back_mux_out),
    .stall_out(stall_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          rd_e;
    bit          wr_e;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          lat;
    bit          rwe;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: access width in bytes from funct3 and direction.
  function automatic int m_size(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input int n, input logic [31:0] a);
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
    int v;
    v = ((1 << n) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
    if (n == 1) return (wd % 256) * 32'h0101_0101;
    if (n == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = m_size(1'b0, f3);
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) % (32'd1 << (8 * n));
    if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; rd_in = '0; pc_in = '0; alu_res_in = '0; sign_immediate_in = '0;
    write_data_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = '0;
    reg_write_en_in = 1'b0; write_back_mux_in = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // One EX/MEM instruction held until the stage releases it; ack after lat REQ cycles.
  task automatic run_op(input vec_t v);
    bit is_mem;
    logic [4:0]  e_rd;
    logic [31:0] e_pc, e_imm;
    logic [1:0]  e_wbm;
    is_mem = v.rd_e | v.wr_e;
    @(posedge clk); #1;
    e_rd = 5'($urandom); e_pc = $urandom; e_imm = $urandom; e_wbm = 2'($urandom);
    valid_in = 1'b1; rd_in = e_rd; pc_in = e_pc; alu_res_in = v.addr;
    sign_immediate_in = e_imm; write_data_in = v.wd; mem_read_in = v.rd_e;
    mem_write_in = v.wr_e; funct3_in = v.f3; reg_write_en_in = v.rwe; write_back_mux_in = e_wbm;
    @(negedge clk);
    if (!is_mem) begin
      chk("pass_rwe", 32'(reg_write_en_out), 32'(v.rwe));
      chk("pass_stall", 32'(stall_out), 0);
      chk("pass_req", 32'(mem_req), 0);
      chk("pass_alu", alu_res_out, v.addr);
      chk("pass_pc", pc_out, e_pc);
      chk("pass_rd", 32'(rd_out), 32'(e_rd));
      chk("pass_imm", sign_immediate_out, e_imm);
      chk("pass_wbm", 32'(write_back_mux_out), 32'(e_wbm));
      chk("pass_data", data_mem_res_out, 0);
    end else if (v.mis) begin
      chk("mis_flag", 32'(misalign_out), 1);
      chk("mis_rwe", 32'(reg_write_en_out), 0);
      chk("mis_stall", 32'(stall_out), 0);
      chk("mis_req", 32'(mem_req), 0);
    end else begin
      chk("cap_stall", 32'(stall_out), 1);
      chk("cap_rwe", 32'(reg_write_en_out), 0);
      chk("cap_mis", 32'(misalign_out), 0);
      for (int k = 1; k <= v.lat; k++) begin
        @(posedge clk); #1;
        mem_ack = (k == v.lat);
        mem_rdata = (k == v.lat) ? v.rdat : $urandom;
        @(negedge clk);
        chk("req_req", 32'(mem_req), 1);
        chk("req_stall", 32'(stall_out), 1);
        chk("req_rwe", 32'(reg_write_en_out), 0);
        chk("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("req_we", 32'(mem_we), 32'(v.wr_e));
        if (v.wr_e) begin
          chk("req_be", 32'(mem_be), 32'(v.be));
          chk("req_wdata", mem_wdata, v.wdata);
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk("resp_stall", 32'(stall_out), 0);
      chk("resp_req", 32'(mem_req), 0);
      chk("resp_rwe", 32'(reg_write_en_out), 32'(v.rwe));
      chk("resp_rd", 32'(rd_out), 32'(e_rd));
      chk("resp_pc", pc_out, e_pc);
      chk("resp_alu", alu_res_out, v.addr);
      chk("resp_wbm", 32'(write_back_mux_out), 32'(e_wbm));
      if (!v.wr_e) chk("resp_data", data_mem_res_out, v.ld);
    end
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_8001};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001};
    tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0056};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h1234_56A5, 32'h0, 2, 1'b0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 1, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 32'h0, 1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D};
    tbl[12] = '{1'b1, 1'b1, 3'b000, 32'h0000_0006, 32'h0000_0077, 32'h0, 1, 1'b0, 1'b0, 4'b0100, 32'h7777_7777, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_007F, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_007F};
    tbl[14] = '{1'b0, 1'b1, 3'b100, 32'h0000_0104, 32'h0123_4567, 32'h0, 3, 1'b0, 1'b0, 4'b1111, 32'h0123_4567, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0};

    idle_inputs();
    rst = 1'b1;
    // Reset holds the MEM/WB controls quiet even with a live passthrough input.
    #1;
    valid_in = 1'b1; reg_write_en_in = 1'b1; alu_res_in = 32'h0000_0001;
    mem_read_in = 1'b1; funct3_in = 3'b010;
    @(negedge clk);
    chk("rst_rwe", 32'(reg_write_en_out), 0);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_mis", 32'(misalign_out), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_data", data_mem_res_out, 0);
    mem_read_in = 1'b0;
    @(negedge clk);
    chk("rst_pass_rwe", 32'(reg_write_en_out), 0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // valid_in low in IDLE forces a bubble even for an aligned memory op.
    mem_read_in = 1'b1; funct3_in = 3'b010; alu_res_in = 32'h100; reg_write_en_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("novalid_rwe", 32'(reg_write_en_out), 0);
      chk("novalid_req", 32'(mem_req), 0);
      chk("novalid_stall", 32'(stall_out), 0);
    end
    idle_inputs();

    for (int i = 0; i < 16; i++) run_op(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      int kind, n;
      kind = $urandom_range(0, 2);
      rv.rd_e  = (kind == 1);
      rv.wr_e  = (kind == 2);
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 1) rv.addr = rv.addr & 32'hFFFF_FFFC;
      rv.wd    = $urandom;
      rv.rdat  = $urandom;
      rv.lat   = $urandom_range(1, 3);
      rv.rwe   = 1'($urandom_range(0, 1));
      n        = m_size(rv.wr_e, rv.f3);
      rv.mis   = m_mis(n, rv.addr);
      rv.be    = m_be(n, rv.addr);
      rv.wdata = m_wdata(n, rv.wd);
      rv.ld    = m_load(rv.f3, rv.addr, rv.rdat);
      run_op(rv);
    end

    // Reset in the middle of REQ abandons the access; a late ack is ignored.
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010;
    alu_res_in = 32'h0000_0300; reg_write_en_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreq_req", 32'(mem_req), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midreq_rst_req", 32'(mem_req), 0);
    chk("midreq_rst_stall", 32'(stall_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_req", 32'(mem_req), 0);
      chk("late_ack_rwe", 32'(reg_write_en_out), 0);
      chk("late_ack_stall", 32'(stall_out), 0);
      chk("late_ack_data", data_mem_res_out, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
